core_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV32I core.
- Owns the program counter and requests instructions from instruction memory with a req/ack handshake.
- Strobes the decode, register-file read, ALU and register-file write stages one at a time.
- Applies branch/jump redirects and traps on fetch timeout, illegal opcode or misaligned target.

---
 rtl/core_pkg.sv | 56 +++++
 rtl/fetch_timeout_counter.sv | 42 ++++
 rtl/core_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_core_sequencer.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32I multi-cycle control path.
//   - state_e       : sequencer FSM state encoding (also exported on state_o)
//   - trap_cause_e  : trap cause codes reported on trap_cause
//   - LegalOpcodes  : opcode[6:2] major-opcode values the core executes
//   - is_legal_opcode() : full opcode legality check (including opcode[1:0])
// No ports; package only.
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned INSTR_BYTES  = 4;

  // Wide enough for any fetch timeout limit in 1..255.
  localparam int unsigned FetchCntW = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StRead   = 3'd3,
    StExec   = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CauseNone         = 2'd0,
    CauseFetchTimeout = 2'd1,
    CauseIllegalOp    = 2'd2,
    CauseMisaligned   = 2'd3
  } trap_cause_e;

  // LOAD, OP-IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL
  localparam int unsigned NumLegalOps = 9;
  localparam logic [NumLegalOps*5-1:0] LegalOpcodes = {
    5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
    5'b01101, 5'b11000, 5'b11001, 5'b11011
  };

  function automatic logic is_legal_opcode(input logic [6:0] op);
    logic legal;
    legal = 1'b0;
    // Compressed / non-32-bit encodings are never legal here.
    if (op[1:0] == 2'b11) begin
      for (int i = 0; i < NumLegalOps; i++) begin
        if (op[6:2] == LegalOpcodes[i*5 +: 5]) begin
          legal = 1'b1;
        end
      end
    end
    return legal;
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// -----------------------------------------------------------------------------
// fetch_timeout_counter
// Wait-cycle counter for a request/acknowledge handshake. Counts cycles while
// enabled, clears on request, and flags when the count has reached the limit.
// Written generically so the same block can guard data-memory waits later.
// Ports:
//   i_clk      clock, state on rising edge
//   i_reset    synchronous active-high reset, count -> 0
//   i_clear    force count to 0 (takes priority over i_enable)
//   i_enable   count one more wait cycle
//   i_limit    expiry threshold
//   o_expired  count == i_limit (registered count, compare only)
// -----------------------------------------------------------------------------
module fetch_timeout_counter
  import core_pkg::*;
#(
  parameter int unsigned Width = FetchCntW
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [Width-1:0] i_limit,
  output logic             o_expired
);

  logic [Width-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      // Saturate at the limit so a stalled owner never sees a wrapped count.
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == i_limit);

endmodule

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
// Multi-cycle control FSM for the RV32I core. Owns the PC, fetches through a
// req/ack handshake, strobes decode / register read / ALU / register write one
// stage per cycle, applies branch redirects and traps on fetch timeout,
// illegal opcode or misaligned redirect target.
//
// Optional feature: define CORE_SEQ_INSTRET_EN to add a 64-bit retired
// instruction counter on output instret.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   run                  1 = execute, 0 = stop at next instruction boundary
//   imem_req/addr/ack    instruction fetch handshake (addr = pc)
//   dec_en               decode latch strobe
//   opcode/rd_valid/rd   decoded instruction fields
//   rf_rd_en             register-file read strobe
//   alu_en               ALU evaluate strobe
//   taken_br/br_target   redirect request, sampled in WB
//   rf_wr_en             register-file write strobe
//   pc                   current instruction address
//   retire               one pulse per completed instruction
//   trap/trap_cause      sticky trap flag and cause
//   state_o              current FSM state (debug)
//   instret              retired count (CORE_SEQ_INSTRET_EN only)
// -----------------------------------------------------------------------------
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned     XLEN          = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC      = '0,
  parameter int unsigned     FETCH_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            dec_en,
  input  logic [6:0]      opcode,
  input  logic            rd_valid,
  input  logic [4:0]      rd,
  output logic            rf_rd_en,
  output logic            alu_en,
  input  logic            taken_br,
  input  logic [XLEN-1:0] br_target,
  output logic            rf_wr_en,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic [2:0]      state_o
`ifdef CORE_SEQ_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  localparam logic [FetchCntW-1:0] TimeoutLimit = FetchCntW'(FETCH_TIMEOUT);

  state_e          r_state;
  state_e          w_state_next;
  logic [XLEN-1:0] r_pc;
  logic            r_trap;
  trap_cause_e     r_trap_cause;
  logic            w_trap_enter;
  trap_cause_e     w_trap_cause_next;
  logic            w_misaligned;
  logic            w_opcode_legal;
  logic            w_fetch_expired;
  logic            w_wb_commit;

  // A redirect to a non-word address traps instead of committing.
  assign w_misaligned   = taken_br && (br_target[1:0] != 2'b00);
  assign w_opcode_legal = is_legal_opcode(opcode);
  assign w_wb_commit    = (r_state == StWb) && !w_misaligned;

  // ---------------------------------------------------------------------------
  // Fetch wait counter: counts FETCH cycles without an ack.
  // ---------------------------------------------------------------------------
  fetch_timeout_counter #(
    .Width (FetchCntW)
  ) u_fetch_timeout_counter (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clear   ((r_state != StFetch) || imem_ack),
    .i_enable  ((r_state == StFetch) && !imem_ack),
    .i_limit   (TimeoutLimit),
    .o_expired (w_fetch_expired)
  );

  // ---------------------------------------------------------------------------
  // State register (plus the architectural state it updates).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_trap       <= 1'b0;
      r_trap_cause <= CauseNone;
    end else begin
      r_state <= w_state_next;
      if (w_trap_enter) begin
        r_trap       <= 1'b1;
        r_trap_cause <= w_trap_cause_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_wb_commit) begin
      // Wraps modulo 2^XLEN by construction.
      r_pc <= taken_br ? br_target : r_pc + XLEN'(INSTR_BYTES);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_trap_enter      = 1'b0;
    w_trap_cause_next = CauseNone;
    unique case (r_state)
      StIdle: begin
        if (run) begin
          w_state_next = StFetch;
        end
      end
      StFetch: begin
        // An ack arriving on the expiry cycle still wins.
        if (imem_ack) begin
          w_state_next = StDecode;
        end else if (w_fetch_expired) begin
          w_state_next      = StTrap;
          w_trap_enter      = 1'b1;
          w_trap_cause_next = CauseFetchTimeout;
        end
      end
      StDecode: begin
        w_state_next = StRead;
      end
      StRead: begin
        if (!w_opcode_legal) begin
          w_state_next      = StTrap;
          w_trap_enter      = 1'b1;
          w_trap_cause_next = CauseIllegalOp;
        end else begin
          w_state_next = StExec;
        end
      end
      StExec: begin
        w_state_next = StWb;
      end
      StWb: begin
        if (w_misaligned) begin
          w_state_next      = StTrap;
          w_trap_enter      = 1'b1;
          w_trap_cause_next = CauseMisaligned;
        end else if (run) begin
          w_state_next = StFetch;
        end else begin
          w_state_next = StIdle;
        end
      end
      StTrap: begin
        w_state_next = StTrap;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state; only the WB write/retire look at inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req = 1'b0;
    dec_en   = 1'b0;
    rf_rd_en = 1'b0;
    alu_en   = 1'b0;
    rf_wr_en = 1'b0;
    retire   = 1'b0;
    unique case (r_state)
      StFetch:  imem_req = 1'b1;
      StDecode: dec_en   = 1'b1;
      StRead:   rf_rd_en = 1'b1;
      StExec:   alu_en   = 1'b1;
      StWb: begin
        retire   = w_wb_commit;
        rf_wr_en = w_wb_commit && rd_valid && (rd != 5'd0);
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign trap       = r_trap;
  assign trap_cause = r_trap_cause;
  assign state_o    = r_state;

`ifdef CORE_SEQ_INSTRET_EN
  logic [63:0] r_instret;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instret <= '0;
    end else if (retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret = r_instret;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer
// Self-checking bench for core_sequencer. Expected retire records (pc, write
// enable, following pc) are queued when an instruction is presented and
// popped when the sequencer retires it.
// -----------------------------------------------------------------------------
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        dec_en;
  logic [6:0]  opcode;
  logic        rd_valid;
  logic [4:0]  rd;
  logic        rf_rd_en;
  logic        alu_en;
  logic        taken_br;
  logic [31:0] br_target;
  logic        rf_wr_en;
  logic [31:0] pc;
  logic        retire;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state_o;
`ifdef CORE_SEQ_INSTRET_EN
  logic [63:0] instret;
`endif

  always #5 clk = ~clk;

  core_sequencer #(
    .XLEN          (32),
    .RESET_PC      (32'h0),
    .FETCH_TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .dec_en     (dec_en),
    .opcode     (opcode),
    .rd_valid   (rd_valid),
    .rd         (rd),
    .rf_rd_en   (rf_rd_en),
    .alu_en     (alu_en),
    .taken_br   (taken_br),
    .br_target  (br_target),
    .rf_wr_en   (rf_wr_en),
    .pc         (pc),
    .retire     (retire),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state_o    (state_o)
`ifdef CORE_SEQ_INSTRET_EN
    ,
    .instret    (instret)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        wr;
    logic [31:0] next_pc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        ack_en;
  logic [31:0] m_pc;

  // Advance one cycle; the memory acks in the same cycle it sees a request
  // when ack_en is set. Outputs are sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_ack = ack_en && imem_req;
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    run       = 1'b0;
    ack_en    = 1'b0;
    imem_ack  = 1'b0;
    opcode    = 7'b0010011;
    rd_valid  = 1'b0;
    rd        = 5'd0;
    taken_br  = 1'b0;
    br_target = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    m_pc  = 32'h0;
    sb.delete();
  endtask

  task automatic set_instr(input logic [6:0] op, input logic rdv, input logic [4:0] rdn,
                           input logic tk, input logic [31:0] tgt);
    opcode    = op;
    rd_valid  = rdv;
    rd        = rdn;
    taken_br  = tk;
    br_target = tgt;
  endtask

  // Present a legal, aligned instruction and queue what its retirement must show.
  task automatic issue(input logic [6:0] op, input logic rdv, input logic [4:0] rdn,
                       input logic tk, input logic [31:0] tgt);
    exp_t e;
    set_instr(op, rdv, rdn, tk, tgt);
    e.pc      = m_pc;
    e.wr      = rdv && (rdn != 5'd0);
    e.next_pc = tk ? tgt : m_pc + 32'd4;
    m_pc      = e.next_pc;
    sb.push_back(e);
  endtask

  task automatic wait_retire(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (retire === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (state_o !== 3'd0 || pc !== 32'h0 || trap !== 1'b0 || trap_cause !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state: state=%0d pc=%h trap=%b cause=%0d, want 0/0/0/0",
               state_o, pc, trap, trap_cause);
    end
    n_cmp++;
    if ({imem_req, dec_en, rf_rd_en, alu_en, rf_wr_en, retire} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want 000000",
               {imem_req, dec_en, rf_rd_en, alu_en, rf_wr_en, retire});
    end
  endtask

  // ADDI x1,x0,21 with zero-wait ack: cycle-exact stage sequence.
  task automatic test_addi();
    exp_t e;
    do_reset();
    ack_en = 1'b1;
    issue(7'b0010011, 1'b1, 5'd1, 1'b0, 32'h0);
    run = 1'b1;
    tick();
    n_cmp++;
    if (state_o !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL addi_fetch: state=%0d req=%b addr=%h, want 1/1/0", state_o, imem_req,
               imem_addr);
    end
    tick();
    n_cmp++;
    if (dec_en !== 1'b1 || state_o !== 3'd2) begin
      n_bad++;
      $display("FAIL addi_decode: dec_en=%b state=%0d, want 1/2", dec_en, state_o);
    end
    tick();
    n_cmp++;
    if (rf_rd_en !== 1'b1 || dec_en !== 1'b0) begin
      n_bad++;
      $display("FAIL addi_read: rf_rd_en=%b dec_en=%b, want 1/0", rf_rd_en, dec_en);
    end
    tick();
    n_cmp++;
    if (alu_en !== 1'b1 || rf_rd_en !== 1'b0) begin
      n_bad++;
      $display("FAIL addi_exec: alu_en=%b rf_rd_en=%b, want 1/0", alu_en, rf_rd_en);
    end
    tick();
    e = sb.pop_front();
    n_cmp++;
    if (retire !== 1'b1 || rf_wr_en !== e.wr || pc !== e.pc || alu_en !== 1'b0) begin
      n_bad++;
      $display("FAIL addi_wb: retire=%b wr=%b pc=%h alu=%b, want 1/%b/%h/0", retire, rf_wr_en,
               pc, alu_en, e.wr, e.pc);
    end
    tick();
    n_cmp++;
    if (pc !== e.next_pc || imem_req !== 1'b1 || imem_addr !== e.next_pc || retire !== 1'b0) begin
      n_bad++;
      $display("FAIL addi_next: pc=%h req=%b addr=%h retire=%b, want %h/1/%h/0", pc, imem_req,
               imem_addr, retire, e.next_pc, e.next_pc);
    end
  endtask

  // Fetch timeout: ack on the cycle the counter hits the limit still wins;
  // one cycle longer without ack traps.
  task automatic test_timeout();
    do_reset();
    run = 1'b1;
    tick();                      // first FETCH cycle (count 0)
    for (int i = 0; i < 14; i++) tick();
    ack_en = 1'b1;
    tick();                      // 16th FETCH cycle, count == 15, ack present
    n_cmp++;
    if (state_o !== 3'd1 || trap !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_edge_hold: state=%0d trap=%b, want 1/0", state_o, trap);
    end
    tick();
    n_cmp++;
    if (state_o !== 3'd2 || trap !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_edge_ack: state=%0d trap=%b, want 2/0", state_o, trap);
    end

    do_reset();
    run = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    n_cmp++;
    if (state_o !== 3'd1 || trap !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_wait: state=%0d trap=%b, want 1/0", state_o, trap);
    end
    tick();
    tick();
    n_cmp++;
    if (trap !== 1'b1 || trap_cause !== 2'd1 || state_o !== 3'd6 || imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_trap: trap=%b cause=%0d state=%0d req=%b, want 1/1/6/0", trap,
               trap_cause, state_o, imem_req);
    end
    do_reset();
    n_cmp++;
    if (trap !== 1'b0 || pc !== 32'h0 || state_o !== 3'd0) begin
      n_bad++;
      $display("FAIL timeout_recover: trap=%b pc=%h state=%0d, want 0/0/0", trap, pc, state_o);
    end
  endtask

  // Taken branch to 0x40, then a taken redirect to misaligned 0x42.
  task automatic test_branch();
    exp_t e;
    bit   ok;
    bit   found;
    do_reset();
    ack_en = 1'b1;
    issue(7'b1101111, 1'b1, 5'd1, 1'b1, 32'h40);
    run = 1'b1;
    wait_retire(ok);
    n_cmp++;
    if (!ok || sb.size() == 0) begin
      n_bad++;
      $display("FAIL branch_retire: retire=%b queued=%0d, want retire=1", retire, sb.size());
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (pc !== e.pc || rf_wr_en !== e.wr) begin
        n_bad++;
        $display("FAIL branch_wb: pc=%h wr=%b, want %h/%b", pc, rf_wr_en, e.pc, e.wr);
      end
      tick();
      n_cmp++;
      if (pc !== 32'h40 || imem_addr !== 32'h40 || imem_req !== 1'b1) begin
        n_bad++;
        $display("FAIL branch_redirect: pc=%h addr=%h req=%b, want 40/40/1", pc, imem_addr,
                 imem_req);
      end
    end
    set_instr(7'b1101111, 1'b1, 5'd3, 1'b1, 32'h42);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (state_o === 3'd5) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!found || retire !== 1'b0 || rf_wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_wb: reached=%b retire=%b wr=%b, want 1/0/0", found, retire,
               rf_wr_en);
    end
    tick();
    n_cmp++;
    if (state_o !== 3'd6 || trap !== 1'b1 || trap_cause !== 2'd3 || pc !== 32'h40) begin
      n_bad++;
      $display("FAIL misalign_trap: state=%0d trap=%b cause=%0d pc=%h, want 6/1/3/40", state_o,
               trap, trap_cause, pc);
    end
  endtask

  // Illegal opcodes: bad major opcode and bad low bits.
  task automatic test_illegal();
    logic [6:0] ops [2];
    bit         seen_alu;
    bit         seen_wr;
    ops[0] = 7'b1111111;
    ops[1] = 7'b0010010;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      set_instr(ops[k], 1'b1, 5'd1, 1'b0, 32'h0);
      ack_en   = 1'b1;
      run      = 1'b1;
      seen_alu = 1'b0;
      seen_wr  = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (alu_en === 1'b1) seen_alu = 1'b1;
        if (rf_wr_en === 1'b1 || retire === 1'b1) seen_wr = 1'b1;
      end
      n_cmp++;
      if (state_o !== 3'd6 || trap !== 1'b1 || trap_cause !== 2'd2 || seen_alu || seen_wr) begin
        n_bad++;
        $display("FAIL illegal_%0d: state=%0d trap=%b cause=%0d alu=%b wr=%b, want 6/1/2/0/0",
                 k, state_o, trap, trap_cause, seen_alu, seen_wr);
      end
    end
  endtask

  // Back-to-back: rd=0 write suppression, no-rd op, jump to 0xFFFFFFFC, wrap.
  task automatic test_back_to_back();
    logic [6:0]  ops  [4];
    logic        rdvs [4];
    logic [4:0]  rds  [4];
    logic        tks  [4];
    logic [31:0] tgts [4];
    exp_t        e;
    bit          ok;
    ops[0] = 7'b0110011; rdvs[0] = 1'b1; rds[0] = 5'd0; tks[0] = 1'b0; tgts[0] = 32'h0;
    ops[1] = 7'b0110111; rdvs[1] = 1'b0; rds[1] = 5'd5; tks[1] = 1'b0; tgts[1] = 32'h0;
    ops[2] = 7'b1100111; rdvs[2] = 1'b1; rds[2] = 5'd2; tks[2] = 1'b1; tgts[2] = 32'hFFFF_FFFC;
    ops[3] = 7'b0010011; rdvs[3] = 1'b1; rds[3] = 5'd7; tks[3] = 1'b0; tgts[3] = 32'h0;
    do_reset();
    ack_en = 1'b1;
    run    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue(ops[k], rdvs[k], rds[k], tks[k], tgts[k]);
      wait_retire(ok);
      n_cmp++;
      if (!ok || sb.size() == 0) begin
        n_bad++;
        $display("FAIL b2b_retire_%0d: retire=%b queued=%0d, want retire=1", k, retire,
                 sb.size());
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (pc !== e.pc || rf_wr_en !== e.wr) begin
          n_bad++;
          $display("FAIL b2b_wb_%0d: pc=%h wr=%b, want %h/%b", k, pc, rf_wr_en, e.pc, e.wr);
        end
        tick();
        n_cmp++;
        if (pc !== e.next_pc || imem_addr !== e.next_pc) begin
          n_bad++;
          $display("FAIL b2b_next_%0d: pc=%h addr=%h, want %h", k, pc, imem_addr, e.next_pc);
        end
      end
    end
  endtask

  // run dropped in DECODE finishes the instruction, then idles; reset mid-FETCH.
  task automatic test_run_drop();
    exp_t e;
    bit   ok;
    bit   req_seen;
    do_reset();
    ack_en = 1'b1;
    issue(7'b0010011, 1'b1, 5'd1, 1'b0, 32'h0);
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    wait_retire(ok);
    n_cmp++;
    if (!ok || sb.size() == 0) begin
      n_bad++;
      $display("FAIL rundrop_retire: retire=%b queued=%0d, want retire=1", retire, sb.size());
    end else begin
      e = sb.pop_front();
      tick();
      n_cmp++;
      if (state_o !== 3'd0 || pc !== e.next_pc) begin
        n_bad++;
        $display("FAIL rundrop_idle: state=%0d pc=%h, want 0/%h", state_o, pc, e.next_pc);
      end
    end
    req_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (imem_req !== 1'b0) req_seen = 1'b1;
    end
    n_cmp++;
    if (req_seen) begin
      n_bad++;
      $display("FAIL rundrop_noreq: imem_req seen=%b, want 0", req_seen);
    end
    run = 1'b1;
    ack_en = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (imem_req !== 1'b0 || state_o !== 3'd0 || pc !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_midfetch: req=%b state=%0d pc=%h, want 0/0/0", imem_req, state_o, pc);
    end
    reset = 1'b0;
    run   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_timeout();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_run_drop();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
